// File: rtl/tdc_therm_decoder.sv
// Reduces each TDC comparison cycle of up/down thermometer words to one signed
// phase-error sample, with bubble-tolerant popcount, peak tracking and slip detection.
module tdc_therm_decoder #(
    parameter int WIDTH    = 32,
    parameter int OUT_W    = 7,
    parameter int SAT_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        up_error,
    input  logic [WIDTH-1:0]        dwn_error,
    output logic signed [OUT_W-1:0] phase_err,
    output logic                    err_valid,
    output logic                    slip,
    output logic                    busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]        FULL     = CNT_W'(WIDTH);
    localparam logic [3:0]              SAT_LIM  = 4'(SAT_HOLD);
    localparam logic signed [OUT_W-1:0] POS_FULL = OUT_W'(WIDTH);
    localparam logic signed [OUT_W-1:0] NEG_FULL = -POS_FULL;

    typedef enum logic [1:0] {IDLE, TRACK, WAIT_CLR} state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    logic [WIDTH-1:0] up_q, dn_q;
    logic [CNT_W-1:0] up_cnt, dn_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            up_q   <= '0;
            dn_q   <= '0;
            up_cnt <= '0;
            dn_cnt <= '0;
        end else begin
            up_q   <= up_error;
            dn_q   <= dwn_error;
            up_cnt <= popcount(up_q);
            dn_cnt <= popcount(dn_q);
        end
    end

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        peak_up_q, peak_up_d, peak_dn_q, peak_dn_d;
    logic [CNT_W-1:0]        max_up, max_dn;
    logic [3:0]              sat_q, sat_d, sat_inc;
    logic signed [OUT_W-1:0] err_d;
    logic                    valid_d, slip_d;
    logic                    any_act, up_sat, dn_sat;

    assign any_act = (up_cnt != '0) || (dn_cnt != '0);
    assign up_sat  = (up_cnt == FULL);
    assign dn_sat  = (dn_cnt == FULL);
    assign max_up  = (up_cnt > peak_up_q) ? up_cnt : peak_up_q;
    assign max_dn  = (dn_cnt > peak_dn_q) ? dn_cnt : peak_dn_q;
    assign sat_inc = sat_q + 4'd1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        peak_up_d = peak_up_q;
        peak_dn_d = peak_dn_q;
        sat_d     = sat_q;
        err_d     = phase_err;
        valid_d   = 1'b0;
        slip_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_act) begin
                    peak_up_d = up_cnt;
                    peak_dn_d = dn_cnt;
                    sat_d     = '0;
                    state_d   = TRACK;
                end
            end
            TRACK: begin
                peak_up_d = max_up;
                peak_dn_d = max_dn;
                if (!any_act) begin
                    // Magnitudes are zero-extended, so the subtraction cannot overflow.
                    err_d   = OUT_W'(max_up) - OUT_W'(max_dn);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (up_sat || dn_sat) begin
                    sat_d = sat_inc;
                    if (sat_inc == SAT_LIM) begin
                        err_d   = up_sat ? POS_FULL : NEG_FULL;
                        valid_d = 1'b1;
                        slip_d  = 1'b1;
                        state_d = WAIT_CLR;
                    end
                end else begin
                    sat_d = '0;
                end
            end
            WAIT_CLR: begin
                if (!any_act) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            peak_up_q <= '0;
            peak_dn_q <= '0;
            sat_q     <= '0;
            phase_err <= '0;
            err_valid <= 1'b0;
            slip      <= 1'b0;
        end else begin
            state_q   <= state_d;
            peak_up_q <= peak_up_d;
            peak_dn_q <= peak_dn_d;
            sat_q     <= sat_d;
            phase_err <= err_d;
            err_valid <= valid_d;
            slip      <= slip_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder: each scenario pushes its expected
// emission (value, slip, edge) and a negedge monitor pops and compares.
module tb_tdc_therm_decoder;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       up_error, dwn_error;
    logic signed [6:0] phase_err;
    logic              err_valid, slip, busy;

    always #5 clk = ~clk;

    tdc_therm_decoder #(.WIDTH(32), .OUT_W(7), .SAT_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .up_error  (up_error),
        .dwn_error (dwn_error),
        .phase_err (phase_err),
        .err_valid (err_valid),
        .slip      (slip),
        .busy      (busy)
    );

    typedef struct {
        int err;
        int slp;
        int at_edge;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   edge_cnt  = 0;
    int   last_edge = 0;

    always @(posedge clk) edge_cnt++;

    task check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Presents one sample; it is captured by the edge numbered last_edge.
    task drive(input logic [31:0] u, input logic [31:0] d);
        up_error  = u;
        dwn_error = d;
        last_edge = edge_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task idle(input int n);
        repeat (n) drive(32'h0, 32'h0);
    endtask

    task push_exp(input int err, input int slp, input int at_edge);
        exp_t e;
        e.err     = err;
        e.slp     = slp;
        e.at_edge = at_edge;
        sb.push_back(e);
    endtask

    task check_all_zero(input string tag);
        check({tag, "_phase_err"}, int'(phase_err), 0);
        check({tag, "_err_valid"}, int'(err_valid), 0);
        check({tag, "_slip"}, int'(slip), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (err_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("phase_err", int'(phase_err), e.err);
                check("slip", int'(slip), e.slp);
                check("latency_edge", edge_cnt, e.at_edge);
            end
        end else if (slip) begin
            check("slip_without_valid", 1, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k5;

        // Reset with random nonzero inputs
        reset     = 1'b0;
        up_error  = $urandom | 32'h1;
        dwn_error = $urandom | 32'h1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("in_reset");
            up_error  = $urandom | 32'h1;
            dwn_error = $urandom | 32'h1;
        end
        up_error  = 32'h0;
        dwn_error = 32'h0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_release");
        idle(4);

        // Up ramp to 5 ones, one down bit on the last sample: +4
        drive(32'h1, 32'h0);
        drive(32'h3, 32'h0);
        drive(32'h7, 32'h0);
        drive(32'hF, 32'h0);
        drive(32'h1F, 32'h1);
        drive(32'h0, 32'h0);
        push_exp(4, 0, last_edge + 2);
        idle(4);

        // Down ramp to 12 ones: -12
        for (int i = 1; i <= 12; i++) drive(32'h0, (32'd1 << i) - 32'd1);
        drive(32'h0, 32'h0);
        push_exp(-12, 0, last_edge + 2);
        idle(4);

        // Bubble in the up code: popcount peak 6
        drive(32'h3, 32'h0);
        drive(32'hF, 32'h0);
        drive(32'h1D, 32'h0);
        drive(32'h3F, 32'h0);
        drive(32'h0, 32'h0);
        push_exp(6, 0, last_edge + 2);
        idle(4);

        // Saturation: first saturated sample opens the cycle, four more declare the slip
        k5 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(32'hFFFF_FFFF, 32'h0);
            if (i == 4) begin
                k5 = last_edge;
                push_exp(32, 1, k5 + 2);
            end
        end
        drive(32'h0, 32'h0);
        drive(32'h0, 32'h0);
        check("busy_wait_clr", int'(busy), 1);
        drive(32'h0, 32'h0);
        check("busy_after_clear", int'(busy), 0);
        idle(4);

        // Reset mid-TRACK discards the partial cycle
        repeat (3) drive(32'h3FF, 32'h0);
        drive(32'h3FF, 32'h0);
        check("busy_tracking", int'(busy), 1);
        reset = 1'b0;
        drive(32'h0, 32'h0);
        drive(32'h0, 32'h0);
        reset = 1'b1;
        idle(3);
        check("busy_after_mid_reset", int'(busy), 0);
        check("err_valid_after_mid_reset", int'(err_valid), 0);

        drive(32'h7, 32'h0);
        drive(32'h7, 32'h0);
        drive(32'h0, 32'h0);
        push_exp(3, 0, last_edge + 2);
        idle(5);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
